find_top2_seq: RTL

- Parametrised sequential top-2 finder. Captures an M-entry vector of N-bit unsigned values on a start pulse, then scans one element per clock.
- Reports the two smallest values (mode 0) or the two largest values (mode 1), with their indices.
- Successor to the fixed-depth min/index scanner. Adds a start/busy/done handshake, a min/max mode, valid flags and defined tie rules.
- Sits in the datapath library beside the synchronous DFF primitives.

---
 rtl/find_top2_pkg.sv | 13 +
 rtl/top2_insert_n.sv | 53 +++++
 rtl/find_top2_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/find_top2_pkg.sv
// Shared types and constants for the sequential top-2 finder.
package find_top2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/top2_insert_n.sv
// Combinational insert step: folds one element into the running best1/best2 pair.
module top2_insert_n
    import find_top2_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 4
) (
    input  logic [N-1:0]  x_i,
    input  logic [IW-1:0] idx_i,
    input  logic          mode_i,
    input  logic [N-1:0]  best1_i,
    input  logic [IW-1:0] idx1_i,
    input  logic          valid1_i,
    input  logic [N-1:0]  best2_i,
    input  logic [IW-1:0] idx2_i,
    input  logic          valid2_i,
    output logic [N-1:0]  best1_o,
    output logic [IW-1:0] idx1_o,
    output logic          valid1_o,
    output logic [N-1:0]  best2_o,
    output logic [IW-1:0] idx2_o,
    output logic          valid2_o
);

    logic better1;
    logic better2;

    // Strict compares keep the earlier index on ties.
    assign better1 = (mode_i == MODE_MAX) ? (x_i > best1_i) : (x_i < best1_i);
    assign better2 = (mode_i == MODE_MAX) ? (x_i > best2_i) : (x_i < best2_i);

    always_comb begin
        best1_o  = best1_i;
        idx1_o   = idx1_i;
        valid1_o = valid1_i;
        best2_o  = best2_i;
        idx2_o   = idx2_i;
        valid2_o = valid2_i;
        if (!valid1_i || better1) begin
            best2_o  = best1_i;
            idx2_o   = idx1_i;
            valid2_o = valid1_i;
            best1_o  = x_i;
            idx1_o   = idx_i;
            valid1_o = 1'b1;
        end else if (!valid2_i || better2) begin
            best2_o  = x_i;
            idx2_o   = idx_i;
            valid2_o = 1'b1;
        end
    end

endmodule

// File: rtl/find_top2_seq.sv
// Sequential top-2 finder: captures a vector on start, scans one element per clock,
// and publishes the two best values with their indices on a one-cycle done pulse.
module find_top2_seq
    import find_top2_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 10,
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [M-1:0][N-1:0] data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [N-1:0]        best1_o,
    output logic [N-1:0]        best2_o,
    output logic [IW-1:0]       idx1_o,
    output logic [IW-1:0]       idx2_o,
    output logic                valid2_o
);

    state_e              state_q, state_d;
    logic [M-1:0][N-1:0] data_q, data_d;
    logic                mode_q, mode_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic [N-1:0]        wb1_q, wb1_d, wb2_q, wb2_d;
    logic [IW-1:0]       wi1_q, wi1_d, wi2_q, wi2_d;
    logic                wv1_q, wv1_d, wv2_q, wv2_d;
    logic [N-1:0]        ob1_q, ob1_d, ob2_q, ob2_d;
    logic [IW-1:0]       oi1_q, oi1_d, oi2_q, oi2_d;
    logic                ov2_q, ov2_d;

    logic [N-1:0]        ins_b1, ins_b2;
    logic [IW-1:0]       ins_i1, ins_i2;
    logic                ins_v1, ins_v2;
    logic                last_elem;

    assign last_elem = (cnt_q == IW'(M - 1));

    top2_insert_n #(
        .N  (N),
        .IW (IW)
    ) u_insert (
        .x_i      (data_q[cnt_q]),
        .idx_i    (cnt_q),
        .mode_i   (mode_q),
        .best1_i  (wb1_q),
        .idx1_i   (wi1_q),
        .valid1_i (wv1_q),
        .best2_i  (wb2_q),
        .idx2_i   (wi2_q),
        .valid2_i (wv2_q),
        .best1_o  (ins_b1),
        .idx1_o   (ins_i1),
        .valid1_o (ins_v1),
        .best2_o  (ins_b2),
        .idx2_o   (ins_i2),
        .valid2_o (ins_v2)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        wb1_d   = wb1_q;
        wi1_d   = wi1_q;
        wv1_d   = wv1_q;
        wb2_d   = wb2_q;
        wi2_d   = wi2_q;
        wv2_d   = wv2_q;
        ob1_d   = ob1_q;
        oi1_d   = oi1_q;
        ob2_d   = ob2_q;
        oi2_d   = oi2_q;
        ov2_d   = ov2_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StScan;
                    data_d  = data_i;
                    mode_d  = mode_i;
                    cnt_d   = '0;
                    // Sentinel loses every compare; the valid bits make it unambiguous.
                    wb1_d   = (mode_i == MODE_MIN) ? '1 : '0;
                    wb2_d   = (mode_i == MODE_MIN) ? '1 : '0;
                    wi1_d   = '0;
                    wi2_d   = '0;
                    wv1_d   = 1'b0;
                    wv2_d   = 1'b0;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StScan: begin
                wb1_d = ins_b1;
                wi1_d = ins_i1;
                wv1_d = ins_v1;
                wb2_d = ins_b2;
                wi2_d = ins_i2;
                wv2_d = ins_v2;
                if (last_elem) begin
                    state_d = StDone;
                    ob1_d   = ins_b1;
                    oi1_d   = ins_i1;
                    ob2_d   = ins_v2 ? ins_b2 : '0;
                    oi2_d   = ins_v2 ? ins_i2 : '0;
                    ov2_d   = ins_v2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            data_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            wb1_q   <= '0;
            wi1_q   <= '0;
            wv1_q   <= 1'b0;
            wb2_q   <= '0;
            wi2_q   <= '0;
            wv2_q   <= 1'b0;
            ob1_q   <= '0;
            oi1_q   <= '0;
            ob2_q   <= '0;
            oi2_q   <= '0;
            ov2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            wb1_q   <= wb1_d;
            wi1_q   <= wi1_d;
            wv1_q   <= wv1_d;
            wb2_q   <= wb2_d;
            wi2_q   <= wi2_d;
            wv2_q   <= wv2_d;
            ob1_q   <= ob1_d;
            oi1_q   <= oi1_d;
            ob2_q   <= ob2_d;
            oi2_q   <= oi2_d;
            ov2_q   <= ov2_d;
        end
    end

    assign busy_o   = (state_q == StScan);
    assign done_o   = (state_q == StDone);
    assign best1_o  = ob1_q;
    assign idx1_o   = oi1_q;
    assign best2_o  = ob2_q;
    assign idx2_o   = oi2_q;
    assign valid2_o = ov2_q;

endmodule
